hd44780_read_operation: RTL and testbench

//  Read-direction bus cycle engine for the HD44780 character LCD; pairs with the existing write-operation block.

---
 rtl/hd44780_pkg.sv | 27 ++
 rtl/hd44780_cycle_timer.sv | 36 +++
 rtl/hd44780_read_operation.sv | 152 +++++++++++++++
 tb/tb_hd44780_read_operation.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hd44780_pkg.sv
// Shared HD44780 timing defaults, read-engine FSM states and RS codes.
// Used by the read/write bus-cycle engines and the LCD controller.
package hd44780_pkg;

    localparam int CLK_PERIOD_PS    = 83333;
    localparam int T_AS_CYC_DEF     = 1;   // RS/RW setup to E rise (>= 40 ns)
    localparam int T_PW_CYC_DEF     = 6;   // E high width (500 ns)
    localparam int T_SAMPLE_CYC_DEF = 4;   // E-high cycle whose closing edge captures DB
    localparam int T_DDR_CYC_DEF    = 2;   // data delay after E rise (160 ns)
    localparam int T_REC_CYC_DEF    = 6;   // E low recovery, RS/RW held
    localparam int T_CYCE_CYC_DEF   = 12;  // full enable cycle (1000 ns)

    localparam logic RS_INSTR = 1'b0;
    localparam logic RS_DATA  = 1'b1;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_SETUP,
        RD_E_HIGH,
        RD_E_LOW
    } rd_state_e;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/hd44780_cycle_timer.sv
// Loadable down-counter; o_expire marks the last cycle of the loaded phase.
module hd44780_cycle_timer #(
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_expire
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count  = count_q;
    assign o_expire = (count_q == '0);

endmodule

// File: rtl/hd44780_read_operation.sv
// HD44780 read bus-cycle engine: RS/RW/E sequencing and DB capture.
// Define HD44780_NIBBLE_MODE_EN for two 4-bit E pulses per read.
module hd44780_read_operation
    import hd44780_pkg::*;
#(
    parameter int T_AS_CYC     = T_AS_CYC_DEF,
    parameter int T_PW_CYC     = T_PW_CYC_DEF,
    parameter int T_SAMPLE_CYC = T_SAMPLE_CYC_DEF,
    parameter int T_REC_CYC    = T_REC_CYC_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic [7:0] i_lcd_db,
    output logic       o_busy,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_bf,
    output logic [6:0] o_ac,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_e
);

    localparam int MAX_AP  = (T_AS_CYC > T_PW_CYC) ? T_AS_CYC : T_PW_CYC;
    localparam int MAX_CYC = (MAX_AP > T_REC_CYC) ? MAX_AP : T_REC_CYC;
    localparam int CNT_W   = cnt_width(MAX_CYC);
    localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(T_PW_CYC - T_SAMPLE_CYC);

    rd_state_e        state_q, state_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_expire;
`ifdef HD44780_NIBBLE_MODE_EN
    logic             second_q, second_d;
    logic             unused_db_lo;
    assign unused_db_lo = ^i_lcd_db[3:0];
`endif

    hd44780_cycle_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (tmr_load),
        .i_load_val(tmr_load_val),
        .o_count   (tmr_count),
        .o_expire  (tmr_expire)
    );

    always_comb begin
        state_d      = state_q;
        rs_d         = rs_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
`ifdef HD44780_NIBBLE_MODE_EN
        second_d     = second_q;
`endif
        case (state_q)
            RD_IDLE: begin
                if (i_start) begin
                    state_d      = RD_SETUP;
                    rs_d         = i_rs;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(T_AS_CYC - 1);
`ifdef HD44780_NIBBLE_MODE_EN
                    second_d     = 1'b0;
`endif
                end
            end
            RD_SETUP: begin
                if (tmr_expire) begin
                    state_d      = RD_E_HIGH;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(T_PW_CYC - 1);
                end
            end
            RD_E_HIGH: begin
                if (tmr_count == SAMPLE_CNT) begin
`ifdef HD44780_NIBBLE_MODE_EN
                    if (second_q) data_d[3:0] = i_lcd_db[7:4];
                    else          data_d[7:4] = i_lcd_db[7:4];
`else
                    data_d = i_lcd_db;
`endif
                end
                if (tmr_expire) begin
                    state_d      = RD_E_LOW;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(T_REC_CYC - 1);
                end
            end
            RD_E_LOW: begin
                if (tmr_expire) begin
`ifdef HD44780_NIBBLE_MODE_EN
                    // Low nibble follows directly; RS/RW stay asserted, no new setup.
                    if (!second_q) begin
                        state_d      = RD_E_HIGH;
                        second_d     = 1'b1;
                        tmr_load     = 1'b1;
                        tmr_load_val = CNT_W'(T_PW_CYC - 1);
                    end else begin
                        state_d = RD_IDLE;
                        valid_d = 1'b1;
                    end
`else
                    state_d = RD_IDLE;
                    valid_d = 1'b1;
`endif
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= RD_IDLE;
            rs_q     <= RS_INSTR;
            data_q   <= '0;
            valid_q  <= 1'b0;
`ifdef HD44780_NIBBLE_MODE_EN
            second_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
`ifdef HD44780_NIBBLE_MODE_EN
            second_q <= second_d;
`endif
        end
    end

    assign o_busy   = (state_q != RD_IDLE);
    assign o_lcd_rw = o_busy;
    assign o_lcd_rs = o_busy & rs_q;
    assign o_lcd_e  = (state_q == RD_E_HIGH);
    assign o_valid  = valid_q;
    assign o_data   = data_q;
    assign o_bf     = data_q[7];
    assign o_ac     = data_q[6:0];

endmodule

// File: tb/tb_hd44780_read_operation.sv
// Self-checking bench for hd44780_read_operation (8-bit or nibble build).
module tb_hd44780_read_operation;

    localparam int T_AS   = 1;
    localparam int T_PW   = 6;
    localparam int T_SAMP = 4;
    localparam int T_REC  = 6;
`ifdef HD44780_NIBBLE_MODE_EN
    localparam int NP = 2;
`else
    localparam int NP = 1;
`endif
    localparam int LAT = T_AS + NP * (T_PW + T_REC) + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rs = 1'b0;
    logic [7:0] db = 8'h00;
    logic       busy, valid, bf, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] data;
    logic [6:0] ac;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int valid_cnt = 0;

    // Reference model: offset within the current read (0 = idle), latched RS, captured byte
    int         m_k = 0;
    logic       m_rs = 1'b0;
    logic [7:0] m_data = 8'h00;

    always #5 clk = ~clk;

    hd44780_read_operation dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_start  (start),
        .i_rs     (rs),
        .i_lcd_db (db),
        .o_busy   (busy),
        .o_valid  (valid),
        .o_data   (data),
        .o_bf     (bf),
        .o_ac     (ac),
        .o_lcd_rs (lcd_rs),
        .o_lcd_rw (lcd_rw),
        .o_lcd_e  (lcd_e)
    );

    typedef struct {
        logic       rs;
        logic [3:0] hi;
        logic [3:0] lo;
        logic [7:0] exp_data;
        logic       exp_bf;
        logic [6:0] exp_ac;
    } vec_t;

    vec_t tbl[7];

    function automatic int pulse_start(input int p);
        return T_AS + 1 + p * (T_PW + T_REC);
    endfunction

    function automatic bit in_pulse(input int k);
        for (int p = 0; p < NP; p++)
            if (k >= pulse_start(p) && k < pulse_start(p) + T_PW) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_all();
        logic b;
        b = (m_k >= 1 && m_k < LAT);
        chk("busy",  {7'd0, busy},   {7'd0, b});
        chk("rw",    {7'd0, lcd_rw}, {7'd0, b});
        chk("rs",    {7'd0, lcd_rs}, {7'd0, b & m_rs});
        chk("e",     {7'd0, lcd_e},  {7'd0, in_pulse(m_k)});
        chk("valid", {7'd0, valid},  {7'd0, m_k == LAT});
        chk("data",  data,           m_data);
        chk("bf",    {7'd0, bf},     {7'd0, m_data[7]});
        chk("ac",    {1'b0, ac},     {1'b0, m_data[6:0]});
    endtask

    task automatic step();
        int nk;
        for (int p = 0; p < NP; p++) begin
            if (m_k == pulse_start(p) + T_SAMP - 1) begin
                if (NP == 1)     m_data = db;
                else if (p == 0) m_data[7:4] = db[7:4];
                else             m_data[3:0] = db[7:4];
            end
        end
        if ((m_k == 0 || m_k == LAT) && start) begin
            nk   = 1;
            m_rs = rs;
        end else if (m_k > 0 && m_k < LAT) begin
            nk = m_k + 1;
        end else begin
            nk = 0;
        end
        @(posedge clk);
        #1;
        m_k = nk;
        cyc++;
        if (valid) valid_cnt++;
        check_all();
    endtask

    task automatic drive_db(input logic [3:0] hi, input logic [3:0] lo);
        if (NP == 1)                            db = {hi, lo};
        else if (m_k < pulse_start(0) + T_SAMP) db = {hi, ~lo};
        else                                    db = {lo, ~hi};
    endtask

    task automatic table_read(input vec_t v);
        rs    = v.rs;
        start = 1'b1;
        drive_db(v.hi, v.lo);
        step();
        start = 1'b0;
        rs    = ~v.rs;
        for (int c = 1; c < LAT; c++) begin
            drive_db(v.hi, v.lo);
            step();
        end
        chk("tbl_valid", {7'd0, valid}, 8'd1);
        chk("tbl_data",  data, v.exp_data);
        chk("tbl_bf",    {7'd0, bf}, {7'd0, v.exp_bf});
        chk("tbl_ac",    {1'b0, ac}, {1'b0, v.exp_ac});
    endtask

    task automatic db_change_read(input int change_cyc);
        rs    = 1'b1;
        db    = 8'h41;
        start = 1'b1;
        step();
        start = 1'b0;
        while (m_k < LAT) begin
            if (m_k >= change_cyc) db = 8'h5A;
            step();
        end
    endtask

    initial begin
        tbl[0] = '{1'b0, 4'h8, 4'hC, 8'h8C, 1'b1, 7'h0C};
        tbl[1] = '{1'b1, 4'h4, 4'h1, 8'h41, 1'b0, 7'h41};
        tbl[2] = '{1'b0, 4'h7, 4'hF, 8'h7F, 1'b0, 7'h7F};
        tbl[3] = '{1'b1, 4'hA, 4'h5, 8'hA5, 1'b1, 7'h25};
        tbl[4] = '{1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 7'h00};
        tbl[5] = '{1'b1, 4'hF, 4'hF, 8'hFF, 1'b1, 7'h7F};
        tbl[6] = '{1'b1, 4'h3, 4'hA, 8'h3A, 1'b0, 7'h3A};

        #1;
        check_all();
        step();
        #2 rst_n = 1'b1;
        step();

        // Back-to-back table reads: each next start lands on the valid cycle
        for (int i = 0; i < 7; i++) table_read(tbl[i]);
        start = 1'b0;
        step();
        chk("idle_after_tbl", {7'd0, busy}, 8'd0);

        // DB change just before / just after the sample edge
        db_change_read(5);
`ifndef HD44780_NIBBLE_MODE_EN
        chk("db_change_c5", data, 8'h5A);
`endif
        step();
        db_change_read(6);
`ifndef HD44780_NIBBLE_MODE_EN
        chk("db_change_c6", data, 8'h41);
`endif
        step();

        // Asynchronous reset while E is high
        rs = 1'b1; db = 8'hC3; start = 1'b1;
        step();
        start = 1'b0;
        while (m_k < 4) step();
        #2 rst_n = 1'b0;
        #1;
        m_k = 0; m_data = 8'h00; m_rs = 1'b0;
        chk("rst_e",     {7'd0, lcd_e},  8'd0);
        chk("rst_rw",    {7'd0, lcd_rw}, 8'd0);
        chk("rst_busy",  {7'd0, busy},   8'd0);
        chk("rst_valid", {7'd0, valid},  8'd0);
        chk("rst_data",  data,           8'd0);
        step();
        rst_n = 1'b1;
        table_read(tbl[0]);
        start = 1'b0;
        step();

        // i_start held high: one read per LAT cycles
        valid_cnt = 0;
        start = 1'b1;
        for (int c = 0; c < 3 * LAT; c++) begin
            rs = 1'($urandom);
            db = 8'($urandom);
            step();
        end
        start = 1'b0;
        chk("held_valid_cnt", 8'(valid_cnt), 8'd3);
        step();
        step();

        // Start pulse during a read is dropped
        valid_cnt = 0;
        rs = 1'b0; db = 8'h92; start = 1'b1;
        step();
        start = 1'b0;
        while (m_k < 5) step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < LAT + 4; c++) step();
        chk("pulse_valid_cnt", 8'(valid_cnt), 8'd1);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            start = ($urandom_range(0, 3) == 0);
            rs    = 1'($urandom);
            db    = 8'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
